pow2_unit: RTL and testbench
============================

Name: pow2_unit

Overview:
- Log-domain back-end of the GELU divide path. Sits directly downstream of the division unit.
- Consumes the Q5.26 base-2 exponent (log2 of |F/s_xi|), result_sign and div_by_zero, and converts back to the linear domain: result = (sign ? -1 : 1) * 2^exponent, in Q5.26.
- Fully pipelined: 3-cycle latency, one result per clock, no backpressure.

Parameters:
- Q, 26, fractional bits of input and output. Only 26 is supported, because the LUT constants are fixed for Q=26.
- W, 32, word width of exponent and result.
- SEG_BITS, 3, number of fraction MSBs used as the segment index (8 segments). Fixed at 3.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  input qualifier from the division unit
- exponent  input  W  signed Q5.26 exponent e
- result_sign  input  1  1 = negate the result
- div_by_zero  input  1  upstream divide-by-zero flag
- valid_out  output  1  result qualifier
- result  output  W  signed Q5.26 value of ±2^e
- overflow  output  1  result saturated (e too large, or div_by_zero)

Behaviour:
- Reset: rst_n=0 asynchronously clears every pipeline register. valid_out=0, result=0, overflow=0. A reset mid-stream discards all in-flight items; no valid_out appears for them.
- Pipeline: 3 stages. valid_in at edge N produces valid_out high from edge N+3, for exactly one cycle per accepted input. The valid bit shifts unconditionally. Data registers load only when their stage valid is 1, so they hold otherwise.
- Stage 1, split:
  - n = e >>> Q (arithmetic, floor).
  - f = e[Q-1:0], unsigned fraction in [0,1).
  - k = f[Q-1:Q-3].
  - r = f[Q-4:0] (23 bits).
  - Register n, k, r, sign and the dz flag.
- Stage 2, mantissa:
  - m = BASE[k] + ((SLOPE[k] * r) >> Q), a Q1.26 value in [1,2).
  - BASE[k] = round(2^(k/8) * 2^26).
  - SLOPE[k] = round(8 * (2^((k+1)/8) - 2^(k/8)) * 2^26).
  - Product width is 50 bits unsigned; shifted value is truncated.
  - BASE[0] = 0x04000000 exactly.
- Stage 3, scale, saturate, sign:
  - If dz=1 or n >= 5: mag = 0x7FFFFFFF, overflow=1.
  - Else if n >= 0: mag = m << n. This cannot overflow for n <= 4, because m < 2^27.
  - Else if n <= -28: mag = 0 (underflow, not flagged).
  - Else: mag = m >> (-n), truncating.
  - result = sign ? -mag : mag. Saturated negative is 0x80000001.
  - A sign applied to mag=0 yields 0.
- Simultaneous events: valid_in is accepted every cycle. Back-to-back inputs produce back-to-back outputs in order.
- Inputs are sampled only when valid_in=1. Don't-care values with valid_in=0 must not alter result.

Optional Feature:
- Macro: POW2_ROUND_EN.
- Defined:
  - The stage-3 right shift rounds half-up: add 1 << (-n-1) before shifting.
  - The stage-2 product shift also rounds half-up.
  - Saturation and underflow rules are unchanged.
  - A rounding carry that reaches 2^31 clamps to 0x7FFFFFFF.
- Undefined: both shifts truncate, as specified above.

Test Plan:
- e=0x04000000 (1.0), sign=0, dz=0 -> result=0x08000000 (2.0), overflow=0, valid_out exactly 3 cycles after valid_in.
- e=0xFC000000 (-1.0) -> result=0x02000000 (0.5). With sign=1 -> result=0xFE000000 (-0.5).
- e=0x02000000 (0.5, k=4, r=0) -> result=BASE[4]=0x05A8279A (√2). e=0x01555555 (log2 of 7/3-2^1 check, fraction only) -> |result/2^26 - 2^f| / 2^f < 0.1%.
- e=0x14000000 (5.0) -> result=0x7FFFFFFF, overflow=1. Same with sign=1 -> 0x80000001. Any e with dz=1 -> saturated, overflow=1.
- e=0x94000000 (-27.0) -> result=0. e=0x98000000 (-26.0) -> result=0x00000001.
- Throughput and reset: drive 6 back-to-back valid inputs -> 6 consecutive valid_out in order with matching values. Assert rst_n=0 with 2 items in flight -> outputs clear immediately, and no valid_out for those items after release.

Source files
------------

// File: rtl/pow2_unit_if.sv
// pow2_unit_if: exponent request and linear-domain response between
// the divide unit, pow2_unit and its consumer.
interface pow2_unit_if #(
    parameter int W = 32
);
    logic         valid_in;
    logic [W-1:0] exponent;
    logic         result_sign;
    logic         div_by_zero;
    logic         valid_out;
    logic [W-1:0] result;
    logic         overflow;

    modport master (
        output valid_in, exponent, result_sign, div_by_zero,
        input  valid_out, result, overflow
    );

    modport slave (
        input  valid_in, exponent, result_sign, div_by_zero,
        output valid_out, result, overflow
    );
endinterface

// File: rtl/pow2_unit.sv
// pow2_unit: signed Q5.26 base-2 exponent to signed Q5.26 +/-2^e, 3 stages.
// Define POW2_ROUND_EN to round the mantissa and scale shifts half-up.
module pow2_unit #(
    parameter int Q        = 26,
    parameter int W        = 32,
    parameter int SEG_BITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    pow2_unit_if.slave bus
);

    localparam int NW    = W - Q;
    localparam int RW    = Q - SEG_BITS;
    localparam int MW    = Q + 2;
    localparam int PW    = 50;
    localparam int N_SAT = W - Q - 1;
    localparam int N_UFL = -(Q + 2);

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W:0]   SAT_W   = {2'b00, {(W-1){1'b1}}};

    // ---------------- stage 1: split ----------------
    logic                 v1_q;
    logic signed [NW-1:0] n1_q;
    logic [SEG_BITS-1:0]  k1_q;
    logic [RW-1:0]        r1_q;
    logic                 s1_q;
    logic                 dz1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            n1_q  <= '0;
            k1_q  <= '0;
            r1_q  <= '0;
            s1_q  <= 1'b0;
            dz1_q <= 1'b0;
        end else begin
            v1_q <= bus.valid_in;
            if (bus.valid_in) begin
                n1_q  <= $signed(bus.exponent[W-1:Q]);
                k1_q  <= bus.exponent[Q-1 -: SEG_BITS];
                r1_q  <= bus.exponent[RW-1:0];
                s1_q  <= bus.result_sign;
                dz1_q <= bus.div_by_zero;
            end
        end
    end

    // ---------------- stage 2: mantissa ----------------
    logic [Q:0]       base_k;
    logic [Q:0]       slope_k;
    logic [PW-1:0]    prod_w;
    logic [PW-Q-1:0]  frac;
    logic [Q-1:0]     prod_unused;
    logic [MW-1:0]    m2_d;

    // Piecewise-linear 2^(k/8 + r/2^26) over eight segments
    always_comb begin
        base_k  = 27'd67108864;
        slope_k = 27'd48590969;
        unique case (k1_q)
            3'd0: begin base_k = 27'd67108864;  slope_k = 27'd48590969; end
            3'd1: begin base_k = 27'd73182735;  slope_k = 27'd52988827; end
            3'd2: begin base_k = 27'd79806339;  slope_k = 27'd57784726; end
            3'd3: begin base_k = 27'd87029429;  slope_k = 27'd63014691; end
            3'd4: begin base_k = 27'd94906266;  slope_k = 27'd68718007; end
            3'd5: begin base_k = 27'd103496017; slope_k = 27'd74937518; end
            3'd6: begin base_k = 27'd112863206; slope_k = 27'd81719943; end
            3'd7: begin base_k = 27'd123078199; slope_k = 27'd89116230; end
        endcase
    end

    always_comb begin
        prod_w = {{(PW-Q-1){1'b0}}, slope_k} * {{(PW-RW){1'b0}}, r1_q};
`ifdef POW2_ROUND_EN
        prod_w = prod_w + (PW'(1) << (Q - 1));
`endif
        {frac, prod_unused} = prod_w;
        m2_d = {1'b0, base_k} + MW'(frac);
    end

    logic                 v2_q;
    logic signed [NW-1:0] n2_q;
    logic [MW-1:0]        m2_q;
    logic                 s2_q;
    logic                 dz2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            n2_q  <= '0;
            m2_q  <= '0;
            s2_q  <= 1'b0;
            dz2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                n2_q  <= n1_q;
                m2_q  <= m2_d;
                s2_q  <= s1_q;
                dz2_q <= dz1_q;
            end
        end
    end

    // ---------------- stage 3: scale, saturate, sign ----------------
    logic [W:0]    mag_w;
    logic [W:0]    m_ext;
    logic [NW-1:0] shr;
    logic [W-1:0]  mag3;
    logic [W-1:0]  res3_d;
    logic          ovf3_d;

    always_comb begin
        mag_w  = '0;
        ovf3_d = 1'b0;
        m_ext  = {{(W+1-MW){1'b0}}, m2_q};
        shr    = NW'(-int'(n2_q));
        if (dz2_q || int'(n2_q) >= N_SAT) begin
            mag_w  = SAT_W;
            ovf3_d = 1'b1;
        end else if (int'(n2_q) >= 0) begin
            mag_w = m_ext << n2_q[2:0];
        end else if (int'(n2_q) > N_UFL) begin
`ifdef POW2_ROUND_EN
            mag_w = (m_ext + ((W+1)'(1) << (shr - NW'(1)))) >> shr;
`else
            mag_w = m_ext >> shr;
`endif
        end
        mag3   = (mag_w[W] | mag_w[W-1]) ? SAT_POS : mag_w[W-1:0];
        res3_d = s2_q ? (W'(0) - mag3) : mag3;
    end

    logic         vo_q;
    logic [W-1:0] res_q;
    logic         ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo_q  <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vo_q <= v2_q;
            if (v2_q) begin
                res_q <= res3_d;
                ovf_q <= ovf3_d;
            end
        end
    end

    assign bus.valid_out = vo_q;
    assign bus.result    = res_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pow2_unit.sv
// tb_pow2_unit: directed and randomized scoreboard bench for pow2_unit.
// A real-arithmetic model predicts each result; a monitor checks outputs in order.
`timescale 1ns/1ps
module tb_pow2_unit;

    localparam real TWO26 = 67108864.0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pow2_unit_if #(.W(32)) bus ();

    pow2_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        bit          ovf;
        bit          acc;
        real         ideal;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc    = 0;
    int          checks = 0;
    int          passes = 0;
    int          nvalid = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // 2^e evaluated from the segment tables defined by their real formulas
    function automatic void model(input logic [31:0] e, input bit s, input bit dz,
                                  output logic [31:0] res, output bit ovf);
        real    ev;
        longint n, f, k, r, base, slope, m, mag, d;
        ev    = real'($signed(e)) / TWO26;
        n     = longint'($rtoi($floor(ev)));
        f     = longint'($signed(e)) - n * 64'sd67108864;
        k     = f / 8388608;
        r     = f % 8388608;
        base  = longint'($rtoi(2.0 ** (real'(k) / 8.0) * TWO26 + 0.5));
        slope = longint'($rtoi(8.0 * (2.0 ** (real'(k + 1) / 8.0)
                                    - 2.0 ** (real'(k) / 8.0)) * TWO26 + 0.5));
`ifdef POW2_ROUND_EN
        m = base + (slope * r + 64'sd33554432) / 64'sd67108864;
`else
        m = base + (slope * r) / 64'sd67108864;
`endif
        ovf = 1'b0;
        if (dz || n >= 5) begin
            mag = 64'sh7FFFFFFF;
            ovf = 1'b1;
        end else if (n >= 0) begin
            mag = m * (64'sd1 << n);
        end else if (n <= -28) begin
            mag = 0;
        end else begin
            d = 64'sd1 << (-n);
`ifdef POW2_ROUND_EN
            mag = (m + d / 2) / d;
`else
            mag = m / d;
`endif
        end
        if (mag > 64'sh7FFFFFFF) mag = 64'sh7FFFFFFF;
        res = s ? (32'h0 - mag[31:0]) : mag[31:0];
    endfunction

    task automatic issue(input logic [31:0] e, input bit s, input bit dz, input exp_t x);
        @(posedge clk);
        #1;
        bus.valid_in    = 1'b1;
        bus.exponent    = e;
        bus.result_sign = s;
        bus.div_by_zero = dz;
        x.cyc = cyc;
        sb.push_back(x);
    endtask

    task automatic send(input logic [31:0] e, input bit s, input bit dz);
        exp_t x;
        model(e, s, dz, x.res, x.ovf);
        x.acc   = 1'b0;
        x.ideal = 0.0;
        issue(e, s, dz, x);
    endtask

    task automatic send_lit(input logic [31:0] e, input bit s, input bit dz,
                            input logic [31:0] res, input bit ovf);
        exp_t x;
        x.res   = res;
        x.ovf   = ovf;
        x.acc   = 1'b0;
        x.ideal = 0.0;
        issue(e, s, dz, x);
    endtask

    task automatic send_acc(input logic [31:0] e);
        exp_t x;
        model(e, 1'b0, 1'b0, x.res, x.ovf);
        x.acc   = 1'b1;
        x.ideal = 2.0 ** (real'($signed(e)) / TWO26);
        issue(e, 1'b0, 1'b0, x);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.valid_in    = 1'b0;
        bus.exponent    = $urandom();
        bus.result_sign = 1'($urandom());
        bus.div_by_zero = 1'($urandom());
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_exp();
        logic [5:0] n;
        if ($urandom_range(7) == 0) return $urandom();
        n = 6'($urandom_range(36)) - 6'd30;
        return {n, 26'($urandom())};
    endfunction

    always @(negedge clk) begin
        exp_t x;
        real  got;
        real  rel;
        if (!rst_n) begin
            last_res = '0;
        end else if (bus.valid_out) begin
            nvalid++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL spurious_valid: got result %h, expected no output", bus.result);
            end else begin
                x = sb.pop_front();
                check("result", bus.result, x.res);
                check("overflow", 32'(bus.overflow), 32'(x.ovf));
                check("latency", 32'(cyc - x.cyc), 32'd3);
                if (x.acc) begin
                    got = real'($signed(bus.result)) / TWO26;
                    rel = (got - x.ideal) / x.ideal;
                    if (rel < 0.0) rel = -rel;
                    checks++;
                    if (rel < 0.001) passes++;
                    else $display("FAIL accuracy: got %f, expected %f", got, x.ideal);
                end
            end
            last_res = bus.result;
        end else begin
            check("hold", bus.result, last_res);
        end
    end

    initial begin
        int n0;
        bus.valid_in    = 1'b0;
        bus.exponent    = '0;
        bus.result_sign = 1'b0;
        bus.div_by_zero = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.valid_out), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send_lit(32'h04000000, 1'b0, 1'b0, 32'h08000000, 1'b0);
        send_lit(32'hFC000000, 1'b0, 1'b0, 32'h02000000, 1'b0);
        send_lit(32'hFC000000, 1'b1, 1'b0, 32'hFE000000, 1'b0);
        send_lit(32'h02000000, 1'b0, 1'b0, 32'h05A8279A, 1'b0);
        send_lit(32'h10000000, 1'b0, 1'b0, 32'h40000000, 1'b0);
        send_lit(32'h14000000, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1);
        send_lit(32'h14000000, 1'b1, 1'b0, 32'h80000001, 1'b1);
        send_lit(32'h12345678, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1);
        send_lit(32'h00000000, 1'b1, 1'b1, 32'h80000001, 1'b1);
        send_lit(32'h98000000, 1'b0, 1'b0, 32'h00000001, 1'b0);
`ifdef POW2_ROUND_EN
        send_lit(32'h94000000, 1'b0, 1'b0, 32'h00000001, 1'b0);
`else
        send_lit(32'h94000000, 1'b0, 1'b0, 32'h00000000, 1'b0);
        send_lit(32'h94000000, 1'b1, 1'b0, 32'h00000000, 1'b0);
`endif
        send_lit(32'h90000000, 1'b1, 1'b0, 32'h00000000, 1'b0);
        send(32'h13FFFFFF, 1'b0, 1'b0);
        send_acc(32'h01555555);
        drain();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) idle();
            else send(rand_exp(), 1'($urandom()), $urandom_range(15) == 0);
        end
        drain();

        send_lit(32'h04000000, 1'b0, 1'b0, 32'h08000000, 1'b0);
        drain();
        send(32'h02000000, 1'b0, 1'b0);
        send(32'h0C000000, 1'b1, 1'b0);
        idle();
        sb.delete();
        n0 = nvalid;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.valid_out), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) idle();
        check("midrst_flushed", 32'(nvalid), 32'(n0));

        send(32'hFE000000, 1'b1, 1'b0);
        send(32'h0A000000, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
